adda_trigger_capture: RTL and testbench

//   Oscilloscope-style ADC capture stage, clocked by the divide-by-2 ADDA sample clock.

---
 rtl/adda_trigger_capture.sv | 135 +++++++++++++
 tb/tb_adda_trigger_capture.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/adda_trigger_capture.sv
// Oscilloscope-style capture stage: circular sample buffer with edge/forced trigger and
// a frozen window of 2**ADDR_W samples around the trigger, with programmable pre-trigger depth.
module adda_trigger_capture #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              trig_force,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_ptr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   pre_q, pre_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   trig_ptr_q, trig_ptr_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                we;
  logic [ADDR_W-1:0]   rd_idx;
  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

  function automatic logic edge_hit(input logic [DATA_W-1:0] prev,
                                    input logic [DATA_W-1:0] cur,
                                    input logic [DATA_W-1:0] level,
                                    input logic              falling);
    if (falling) return (prev >= level) && (cur < level);
    else         return (prev < level) && (cur >= level);
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    start_d    = start_q;
    trig_ptr_d = trig_ptr_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    we         = 1'b0;
    if (arm) begin
      // Arm restarts from any state; this cycle stores nothing.
      pre_d      = pretrig;
      cnt_d      = '0;
      prev_vld_d = 1'b0;
      state_d    = (pretrig == '0) ? S_WAIT : S_PRE;
    end else begin
      case (state_q)
        S_PRE: begin
          we    = 1'b1;
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q + ADDR_W'(1) == pre_q) state_d = S_WAIT;
        end
        S_WAIT: begin
          we = 1'b1;
          if (trig_force || (prev_vld_q && edge_hit(prev_q, adc_data, trig_level, trig_edge))) begin
            trig_ptr_d = wr_ptr_q;
            start_d    = wr_ptr_q - pre_q;
            // Samples still to store after the trigger: DEPTH-1-pretrig.
            cnt_d      = ~pre_q;
            state_d    = (~pre_q == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          we    = 1'b1;
          cnt_d = cnt_q - ADDR_W'(1);
          if (cnt_q == ADDR_W'(1)) state_d = S_DONE;
        end
        default: ;
      endcase
    end
    if (we) begin
      wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
      prev_d     = adc_data;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      pre_q      <= '0;
      cnt_q      <= '0;
      start_q    <= '0;
      trig_ptr_q <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      trig_ptr_q <= trig_ptr_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_ptr_q] <= adc_data;
  end

  assign rd_idx = start_q + rd_addr;

  // Separate process from the write, so a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (rst)        rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_idx];
  end

  assign busy     = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign done     = (state_q == S_DONE);
  assign trig_ptr = trig_ptr_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_adda_trigger_capture.sv
// Directed bench for adda_trigger_capture with DEPTH=16 and a bench-driven sample ramp.
module tb_adda_trigger_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] adc_data;
  logic       arm;
  logic [3:0] pretrig;
  logic [7:0] trig_level;
  logic       trig_edge;
  logic       trig_force;
  logic       busy;
  logic       done;
  logic [3:0] trig_ptr;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_err    = 0;
  int wr_model = 0;
  bit ramp_dn  = 1'b0;

  typedef struct {
    string name;
    int    pretrig;
    int    level;
    bit    fall;
    int    start;
    bit    down;
    int    force_at;
    int    exp_writes;
    int    exp_trig_n;
    int    exp_idx0;
  } cap_t;

  cap_t tbl [5];

  always #5 clk = ~clk;

  adda_trigger_capture #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .arm        (arm),
    .pretrig    (pretrig),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .trig_force (trig_force),
    .busy       (busy),
    .done       (done),
    .trig_ptr   (trig_ptr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    adc_data = ramp_dn ? adc_data - 8'd1 : adc_data + 8'd1;
  endtask

  task automatic do_arm(input cap_t v);
    adc_data   = 8'(v.start);
    ramp_dn    = v.down;
    trig_level = 8'(v.level);
    trig_edge  = v.fall;
    pretrig    = 4'(v.pretrig);
    arm        = 1'b1;
    step();
    arm        = 1'b0;
  endtask

  task automatic finish_capture(input cap_t v);
    int         k;
    bit         got;
    int         busy_bad;
    logic [7:0] expv;
    k = 0; got = 1'b0; busy_bad = 0; expv = '0;
    while (!got && k < 400) begin
      k++;
      trig_force = (k == v.force_at);
      step();
      trig_force = 1'b0;
      if (done) got = 1'b1;
      else if (!busy) busy_bad++;
    end
    check({v.name, "_cycles_to_done"}, got ? k : -1, v.exp_writes);
    check({v.name, "_busy_low_early"}, busy_bad, 0);
    check({v.name, "_done"}, done, 1);
    check({v.name, "_busy_after"}, busy, 0);
    check({v.name, "_trig_ptr"}, trig_ptr, (wr_model + v.exp_trig_n - 1) % 16);
    wr_model = (wr_model + v.exp_writes) % 16;
    for (int i = 0; i < 16; i++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(i);
      step();
      expv = v.down ? 8'(v.exp_idx0 - i) : 8'(v.exp_idx0 + i);
      check($sformatf("%s_idx%0d", v.name, i), rd_data, expv);
    end
    rd_en   = 1'b0;
    rd_addr = 4'd0;
    step();
    check({v.name, "_rd_hold"}, rd_data, expv);
  endtask

  initial begin
    cap_t v5, v6, v7;
    // name, pretrig, level, fall, start, down, force_at, writes, trig#, idx0
    tbl[0] = '{"rise_pre4",   4,  40, 1'b0,  30, 1'b0, -1,  21,  10, 36};
    tbl[1] = '{"fall_pre0",   0,  90, 1'b1, 100, 1'b1, -1,  26,  11, 89};
    tbl[2] = '{"rise_pre15", 15,  50, 1'b0,  30, 1'b0, -1,  20,  20, 35};
    tbl[3] = '{"pre_edge",    8,  40, 1'b0,  38, 1'b0, -1, 265, 258, 32};
    tbl[4] = '{"force",       3, 255, 1'b0,  10, 1'b0, 10,  22,  10, 17};
    v5     = '{"rearm2",      4,  60, 1'b0,  44, 1'b0, -1,  27,  16, 56};
    v6     = '{"rst_cap",     2, 200, 1'b0,  10, 1'b0, -1,   0,   0,  0};

    rst = 1'b1; adc_data = '0; arm = 1'b0; pretrig = '0; trig_level = '0;
    trig_edge = 1'b0; trig_force = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_trig_ptr", trig_ptr, 0);
    check("reset_rd_data", rd_data, 0);
    rst = 1'b0;
    step();

    for (int t = 0; t < 5; t++) begin
      do_arm(tbl[t]);
      finish_capture(tbl[t]);
    end

    // Re-arm three samples into POST: the first capture must be abandoned.
    do_arm(tbl[0]);
    repeat (13) step();
    check("rearm_busy_in_post", busy, 1);
    check("rearm_done_in_post", done, 0);
    wr_model = (wr_model + 13) % 16;
    do_arm(v5);
    check("rearm_done_after_arm", done, 0);
    check("rearm_busy_after_arm", busy, 1);
    finish_capture(v5);

    // Reset while waiting for a trigger, then a fresh capture.
    do_arm(v6);
    repeat (5) step();
    check("rst_busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_trig_ptr", trig_ptr, 0);
    check("rst_rd_data", rd_data, 0);
    wr_model = 0;
    repeat (5) step();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    v7 = tbl[0];
    v7.name = "after_rst";
    do_arm(v7);
    finish_capture(v7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
